coram_channel_mem: RTL and testbench

- CoRAM endpoint connecting user logic to a software control thread.
- Combines a bidirectional message channel with a single-port user memory. The control thread reaches that memory through a private second (DMA) port.
- Channel: two independent synchronous FIFOs, one user→thread and one thread→user.
- Sits between the user datapath (stencil kernel) and the control-thread/DMA fabric.

---
 rtl/coram_channel_mem_pkg.sv | 8 +
 rtl/coram_sync_fifo.sv | 83 ++++++++
 rtl/coram_channel_mem.sv | 101 ++++++++++
 tb/tb_coram_channel_mem.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/coram_channel_mem_pkg.sv
// Shared defaults for the CoRAM channel/memory endpoint and its FIFOs.
package coram_channel_mem_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_LEN    = 9;
  localparam int DEF_CH_ADDR_LEN = 4;

endpackage

// File: rtl/coram_sync_fifo.sv
// Synchronous FIFO with a registered dequeue output, one per channel direction.
module coram_sync_fifo
  import coram_channel_mem_pkg::*;
#(
  parameter int DW          = DEF_DATA_WIDTH,
  parameter int CH_ADDR_LEN = DEF_CH_ADDR_LEN
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] D,
  input  logic          ENQ,
  output logic          FULL,
  output logic [DW-1:0] Q,
  input  logic          DEQ,
  output logic          EMPTY
);

  localparam int DEPTH = 1 << CH_ADDR_LEN;
  localparam logic [CH_ADDR_LEN:0] DEPTH_CNT = DEPTH[CH_ADDR_LEN:0];

  logic [DW-1:0]          storage [DEPTH];
  logic [CH_ADDR_LEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [CH_ADDR_LEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [CH_ADDR_LEN:0]   count_q, count_d;
  logic [DW-1:0]          q_q, q_d;
  logic                   full;
  logic                   empty;
  logic                   do_enq;
  logic                   do_deq;

  // Strobe semantics: ENQ takes effect only while FULL is low, DEQ only while
  // EMPTY is low; both flags come from the registered count, so an entry
  // written this cycle is first visible to DEQ on the next one.
  assign full   = (count_q == DEPTH_CNT);
  assign empty  = (count_q == '0);
  assign do_enq = ENQ && !full;
  assign do_deq = DEQ && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    q_d      = q_q;
    if (do_enq) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      q_d      = storage[rd_ptr_q];
    end
    case ({do_enq, do_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      q_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      q_q      <= q_d;
    end
  end

  // Storage contents are not reset; the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (!RST && do_enq) begin
      storage[wr_ptr_q] <= D;
    end
  end

  assign FULL  = full;
  assign EMPTY = empty;
  assign Q     = q_q;

endmodule

// File: rtl/coram_channel_mem.sv
// CoRAM endpoint: bidirectional user/thread message channel plus a
// dual-port memory whose second port belongs to the control thread's DMA.
module coram_channel_mem
  import coram_channel_mem_pkg::*;
#(
  parameter string CORAM_THREAD_NAME = "undefined",
  parameter int    CORAM_ID          = 0,
  parameter int    CORAM_SUB_ID      = 0,
  parameter int    CORAM_ADDR_LEN    = DEF_ADDR_LEN,
  parameter int    CORAM_CH_ADDR_LEN = DEF_CH_ADDR_LEN,
  parameter int    CORAM_DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [CORAM_DATA_WIDTH-1:0] CH_D,
  input  logic                        CH_ENQ,
  output logic                        CH_FULL,
  output logic [CORAM_DATA_WIDTH-1:0] CH_Q,
  input  logic                        CH_DEQ,
  output logic                        CH_EMPTY,
  input  logic [CORAM_ADDR_LEN-1:0]   MEM_ADDR,
  input  logic [CORAM_DATA_WIDTH-1:0] MEM_D,
  input  logic                        MEM_WE,
  output logic [CORAM_DATA_WIDTH-1:0] MEM_Q,
  input  logic [CORAM_DATA_WIDTH-1:0] T_CH_D,
  input  logic                        T_CH_ENQ,
  output logic                        T_CH_FULL,
  output logic [CORAM_DATA_WIDTH-1:0] T_CH_Q,
  input  logic                        T_CH_DEQ,
  output logic                        T_CH_EMPTY,
  input  logic [CORAM_ADDR_LEN-1:0]   T_MEM_ADDR,
  input  logic [CORAM_DATA_WIDTH-1:0] T_MEM_D,
  input  logic                        T_MEM_WE,
  output logic [CORAM_DATA_WIDTH-1:0] T_MEM_Q
);

  localparam int DW        = CORAM_DATA_WIDTH;
  localparam int MEM_DEPTH = 1 << CORAM_ADDR_LEN;

  // User -> thread direction.
  coram_sync_fifo #(
    .DW          (DW),
    .CH_ADDR_LEN (CORAM_CH_ADDR_LEN)
  ) u_fifo_u2t (
    .CLK   (CLK),
    .RST   (RST),
    .D     (CH_D),
    .ENQ   (CH_ENQ),
    .FULL  (CH_FULL),
    .Q     (T_CH_Q),
    .DEQ   (T_CH_DEQ),
    .EMPTY (T_CH_EMPTY)
  );

  // Thread -> user direction.
  coram_sync_fifo #(
    .DW          (DW),
    .CH_ADDR_LEN (CORAM_CH_ADDR_LEN)
  ) u_fifo_t2u (
    .CLK   (CLK),
    .RST   (RST),
    .D     (T_CH_D),
    .ENQ   (T_CH_ENQ),
    .FULL  (T_CH_FULL),
    .Q     (CH_Q),
    .DEQ   (CH_DEQ),
    .EMPTY (CH_EMPTY)
  );

  logic [DW-1:0] mem [MEM_DEPTH];
  logic [DW-1:0] mem_q_q, mem_q_d;
  logic [DW-1:0] t_mem_q_q, t_mem_q_d;
  logic          t_write_ok;

  // Reads sample the array before this edge's writes land: old data wins.
  always_comb begin
    mem_q_d   = mem[MEM_ADDR];
    t_mem_q_d = mem[T_MEM_ADDR];
  end

  always_ff @(posedge CLK) begin
    mem_q_q   <= mem_q_d;
    t_mem_q_q <= t_mem_q_d;
  end

  // On a same-address double write the user port takes priority.
  assign t_write_ok = T_MEM_WE && !(MEM_WE && (MEM_ADDR == T_MEM_ADDR));

  always_ff @(posedge CLK) begin
    if (MEM_WE) begin
      mem[MEM_ADDR] <= MEM_D;
    end
    if (t_write_ok) begin
      mem[T_MEM_ADDR] <= T_MEM_D;
    end
  end

  assign MEM_Q   = mem_q_q;
  assign T_MEM_Q = t_mem_q_q;

endmodule

// File: tb/tb_coram_channel_mem.sv
// Randomized and directed bench for coram_channel_mem against a queue/array model.
module tb_coram_channel_mem;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int DEPTH = 16;
  localparam int MEMN  = 1 << AW;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [DW-1:0] CH_D, CH_Q, MEM_D, MEM_Q, T_CH_D, T_CH_Q, T_MEM_D, T_MEM_Q;
  logic          CH_ENQ, CH_FULL, CH_DEQ, CH_EMPTY, MEM_WE;
  logic          T_CH_ENQ, T_CH_FULL, T_CH_DEQ, T_CH_EMPTY, T_MEM_WE;
  logic [AW-1:0] MEM_ADDR, T_MEM_ADDR;

  coram_channel_mem dut (
    .CLK        (CLK),
    .RST        (RST),
    .CH_D       (CH_D),
    .CH_ENQ     (CH_ENQ),
    .CH_FULL    (CH_FULL),
    .CH_Q       (CH_Q),
    .CH_DEQ     (CH_DEQ),
    .CH_EMPTY   (CH_EMPTY),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_D      (MEM_D),
    .MEM_WE     (MEM_WE),
    .MEM_Q      (MEM_Q),
    .T_CH_D     (T_CH_D),
    .T_CH_ENQ   (T_CH_ENQ),
    .T_CH_FULL  (T_CH_FULL),
    .T_CH_Q     (T_CH_Q),
    .T_CH_DEQ   (T_CH_DEQ),
    .T_CH_EMPTY (T_CH_EMPTY),
    .T_MEM_ADDR (T_MEM_ADDR),
    .T_MEM_D    (T_MEM_D),
    .T_MEM_WE   (T_MEM_WE),
    .T_MEM_Q    (T_MEM_Q)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;

  logic [DW-1:0] u2t_exp_q[$];
  logic [DW-1:0] t2u_exp_q[$];
  logic [DW-1:0] exp_ch_q, exp_t_ch_q;
  logic [DW-1:0] mem_m [MEMN];
  bit            mem_v [MEMN];
  logic [DW-1:0] exp_mem_q, exp_t_mem_q;
  bit            exp_mem_v, exp_t_mem_v;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model update for one rising edge, using the inputs applied during the cycle.
  task automatic model_edge();
    int n_u2t;
    int n_t2u;
    n_u2t = u2t_exp_q.size();
    n_t2u = t2u_exp_q.size();
    if (RST) begin
      u2t_exp_q.delete();
      t2u_exp_q.delete();
      exp_ch_q   = '0;
      exp_t_ch_q = '0;
    end else begin
      if (T_CH_DEQ && n_u2t > 0) exp_t_ch_q = u2t_exp_q.pop_front();
      if (CH_ENQ && n_u2t < DEPTH) u2t_exp_q.push_back(CH_D);
      if (CH_DEQ && n_t2u > 0) exp_ch_q = t2u_exp_q.pop_front();
      if (T_CH_ENQ && n_t2u < DEPTH) t2u_exp_q.push_back(T_CH_D);
    end
    exp_mem_q   = mem_m[MEM_ADDR];
    exp_mem_v   = mem_v[MEM_ADDR];
    exp_t_mem_q = mem_m[T_MEM_ADDR];
    exp_t_mem_v = mem_v[T_MEM_ADDR];
    if (T_MEM_WE) begin
      mem_m[T_MEM_ADDR] = T_MEM_D;
      mem_v[T_MEM_ADDR] = 1'b1;
    end
    if (MEM_WE) begin
      mem_m[MEM_ADDR] = MEM_D;
      mem_v[MEM_ADDR] = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("ch_full",    {31'd0, CH_FULL},    {31'd0, (t2u_exp_q.size() == DEPTH)} & 32'h0 | {31'd0, (u2t_exp_q.size() == DEPTH)});
    check("ch_empty",   {31'd0, CH_EMPTY},   {31'd0, (t2u_exp_q.size() == 0)});
    check("t_ch_full",  {31'd0, T_CH_FULL},  {31'd0, (t2u_exp_q.size() == DEPTH)});
    check("t_ch_empty", {31'd0, T_CH_EMPTY}, {31'd0, (u2t_exp_q.size() == 0)});
    check("ch_q",   CH_Q,   exp_ch_q);
    check("t_ch_q", T_CH_Q, exp_t_ch_q);
    if (exp_mem_v)   check("mem_q",   MEM_Q,   exp_mem_q);
    if (exp_t_mem_v) check("t_mem_q", T_MEM_Q, exp_t_mem_q);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    CH_ENQ = 0; CH_DEQ = 0; T_CH_ENQ = 0; T_CH_DEQ = 0;
    MEM_WE = 0; T_MEM_WE = 0;
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    RST = 1; CH_D = '0; T_CH_D = '0; MEM_D = '0; T_MEM_D = '0;
    MEM_ADDR = '0; T_MEM_ADDR = '0;
    idle();
    exp_ch_q = '0; exp_t_ch_q = '0;
    exp_mem_v = 0; exp_t_mem_v = 0;
    for (int i = 0; i < MEMN; i++) mem_v[i] = 0;
    cycle(); cycle();
    RST = 0;
    check("rst_ch_empty", {31'd0, CH_EMPTY}, 32'd1);
    check("rst_t_ch_empty", {31'd0, T_CH_EMPTY}, 32'd1);
    check("rst_ch_q", CH_Q, 32'd0);
    check("rst_t_ch_q", T_CH_Q, 32'd0);

    // single thread->user message
    T_CH_D = 32'h100; T_CH_ENQ = 1; cycle(); idle();
    check("one_not_empty", {31'd0, CH_EMPTY}, 32'd0);
    CH_DEQ = 1; cycle(); idle();
    check("one_q", CH_Q, 32'h100);
    check("one_empty", {31'd0, CH_EMPTY}, 32'd1);
    cycle();
    check("one_q_hold", CH_Q, 32'h100);

    // fill user->thread to full, overflow dropped, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      CH_D = i; CH_ENQ = 1; cycle();
    end
    check("fill_full", {31'd0, CH_FULL}, 32'd1);
    CH_D = 32'hAA; cycle(); idle();
    for (int i = 0; i < DEPTH; i++) begin
      T_CH_DEQ = 1; cycle();
      check("drain_order", T_CH_Q, i);
    end
    idle();
    check("drain_empty", {31'd0, T_CH_EMPTY}, 32'd1);

    // simultaneous enq/deq at count 1, then wrap-around pairs
    T_CH_D = 32'h55; T_CH_ENQ = 1; cycle();
    T_CH_D = 32'h56; CH_DEQ = 1; cycle();
    check("pair_q", CH_Q, 32'h55);
    check("pair_not_empty", {31'd0, CH_EMPTY}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      T_CH_D = 32'h200 + i; T_CH_ENQ = 1; CH_DEQ = 1; cycle();
      check("wrap_q", CH_Q, (i == 0) ? 32'h56 : 32'h200 + i - 1);
    end
    idle(); CH_DEQ = 1; cycle();
    check("wrap_last", CH_Q, 32'h227);

    // dequeue on empty holds Q
    cycle(); idle();
    check("empty_deq_hold", CH_Q, 32'h227);
    T_CH_D = 32'h333; T_CH_ENQ = 1; cycle(); idle();
    CH_DEQ = 1; cycle(); idle();
    check("after_empty_deq", CH_Q, 32'h333);

    // DMA writes, user reads back with one-cycle latency
    for (int i = 0; i < 3; i++) begin
      T_MEM_ADDR = i; T_MEM_D = 32'h10 * (i + 1); T_MEM_WE = 1; cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      MEM_ADDR = i; cycle();
      check("mem_rd", MEM_Q, 32'h10 * (i + 1));
    end

    // read-during-write across ports, and double-write priority
    T_MEM_ADDR = 5; T_MEM_D = 32'h1234; T_MEM_WE = 1; cycle(); idle();
    MEM_ADDR = 5; MEM_D = 32'h9999999; MEM_WE = 1; cycle(); idle();
    check("rdw_old", T_MEM_Q, 32'h1234);
    cycle();
    check("rdw_new", T_MEM_Q, 32'h9999999);
    MEM_ADDR = 7; MEM_D = 1; MEM_WE = 1; T_MEM_ADDR = 7; T_MEM_D = 2; T_MEM_WE = 1; cycle(); idle();
    cycle();
    check("coll_user", MEM_Q, 32'd1);
    check("coll_dma", T_MEM_Q, 32'd1);

    // mid-operation reset discards queued entries
    for (int i = 0; i < 5; i++) begin
      CH_D = $urandom; CH_ENQ = 1; T_CH_D = $urandom; T_CH_ENQ = 1; cycle();
    end
    idle(); RST = 1; cycle(); RST = 0;
    check("midrst_empty", {31'd0, T_CH_EMPTY}, 32'd1);
    check("midrst_q", CH_Q, 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      CH_D       = $urandom;
      T_CH_D     = $urandom;
      CH_ENQ     = ($urandom_range(0, 99) < 55);
      T_CH_ENQ   = ($urandom_range(0, 99) < 50);
      CH_DEQ     = ($urandom_range(0, 99) < 45);
      T_CH_DEQ   = ($urandom_range(0, 99) < 50);
      MEM_ADDR   = $urandom_range(0, 15);
      T_MEM_ADDR = $urandom_range(0, 15);
      MEM_D      = $urandom;
      T_MEM_D    = $urandom;
      MEM_WE     = ($urandom_range(0, 99) < 40);
      T_MEM_WE   = ($urandom_range(0, 99) < 40);
      RST        = ($urandom_range(0, 499) == 0);
      cycle();
    end
    RST = 0; idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
